// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the CODEC DAC path: derives xck/bclk/lrck from the
// audio clock, applies swap/mix/mute and serialises a 16-bit sample pair
// MSB-first, one bit clock after each LR clock edge.
module i2s_dac_tx #(
  parameter int BCLK_HALF = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exchan,
  input  logic        mix,
  input  logic        mute,
  input  logic [15:0] ldata,
  input  logic [15:0] rdata,
  output logic        sample_strobe,
  output logic        aud_xck,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat
);

  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] K_MAX   = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] K_SLOT  = BW'(SLOT_BITS);
  localparam logic [BW-1:0] K_R1    = BW'(SLOT_BITS + 1);
  localparam logic [BW-1:0] K_ONE   = BW'(1);
  localparam logic [BW-1:0] K_16    = BW'(16);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [15:0]   l_shadow;
  logic [15:0]   r_shadow;
  logic [15:0]   ch_a;
  logic [15:0]   ch_b;
  logic [15:0]   l_next;
  logic [15:0]   r_next;
  logic [BW-1:0] l_off;
  logic [BW-1:0] r_off;
  logic          bclk_fall;
  logic          dat_next;

  // Falling bit-clock edge decision: bclk is high and the divider wraps now.
  assign bclk_fall = aud_bclk && (div_cnt == DIV_MAX);

  // Channel swap, centred mix and mute, evaluated on the live inputs.
  always_comb begin
    ch_a   = exchan ? rdata : ldata;
    ch_b   = exchan ? ldata : rdata;
    l_next = ch_a;
    r_next = ch_b;
    if (mute) begin
      l_next = '0;
      r_next = '0;
    end else if (mix) begin
      l_next = ($signed(ch_a) >>> 1) + ($signed(ch_b) >>> 2);
      r_next = ($signed(ch_b) >>> 1) + ($signed(ch_a) >>> 2);
    end
  end

  // Serial bit for the current slot index; offsets wrap to large values
  // outside the 16 data positions, so one unsigned compare covers each range.
  always_comb begin
    l_off    = bit_cnt - K_ONE;
    r_off    = bit_cnt - K_R1;
    dat_next = 1'b0;
    if (l_off < K_16)
      dat_next = l_shadow[4'd15 - l_off[3:0]];
    else if (r_off < K_16)
      dat_next = r_shadow[4'd15 - r_off[3:0]];
  end

  // Free-running codec master clock at clk/2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aud_xck <= 1'b0;
    else        aud_xck <= ~aud_xck;
  end

  // Bit-clock divider: toggle bclk each time div_cnt wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt  <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Frame sequencing on each bclk fall: lrck, data, sample latch and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      aud_daclrck   <= 1'b0;
      aud_dacdat    <= 1'b0;
      sample_strobe <= 1'b0;
      l_shadow      <= '0;
      r_shadow      <= '0;
    end else begin
      sample_strobe <= bclk_fall && (bit_cnt == '0);
      if (bclk_fall) begin
        bit_cnt     <= (bit_cnt == K_MAX) ? '0 : bit_cnt + 1'b1;
        aud_daclrck <= (bit_cnt >= K_SLOT);
        aud_dacdat  <= dat_next;
        if (bit_cnt == '0) begin
          l_shadow <= l_next;
          r_shadow <= r_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx at default parameters (8-clk bclk, 512-clk frame).
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exchan, mix, mute;
  logic [15:0] ldata, rdata;
  logic        sample_strobe, aud_xck, aud_bclk, aud_daclrck, aud_dacdat;

  int checks = 0;
  int failures = 0;

  i2s_dac_tx #(.BCLK_HALF(4), .SLOT_BITS(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exchan        (exchan),
    .mix           (mix),
    .mute          (mute),
    .ldata         (ldata),
    .rdata         (rdata),
    .sample_strobe (sample_strobe),
    .aud_xck       (aud_xck),
    .aud_bclk      (aud_bclk),
    .aud_daclrck   (aud_daclrck),
    .aud_dacdat    (aud_dacdat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the strobe; returns just after the strobe edge.
  task automatic wait_strobe(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (sample_strobe) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, {63'd0, found}, 64'd1);
  endtask

  // Samples dacdat/lrck/bclk at each of the 64 bclk rises of the frame whose
  // strobe was just seen. Rise j carries the bit chosen at fall index j.
  task automatic capture(input logic mid_change, output logic [15:0] lw,
                         output logic [15:0] rw, output logic [63:0] rest,
                         output logic [63:0] lr, output logic [63:0] hi);
    logic [63:0] frame;
    frame = '0;
    lr    = '0;
    hi    = '0;
    for (int j = 0; j < 64; j++) begin
      repeat ((j == 0) ? 4 : 8) @(posedge clk);
      #1;
      frame[j] = aud_dacdat;
      lr[j]    = aud_daclrck;
      hi[j]    = aud_bclk;
      if (mid_change && j == 8) ldata = 16'hFFFF;
    end
    for (int i = 0; i < 16; i++) begin
      lw[15-i] = frame[1+i];
      rw[15-i] = frame[33+i];
    end
    rest = frame & ~(64'h0001_FFFE_0001_FFFE);
  endtask

  task automatic frame_check(input string tag, input logic mid_change,
                             input logic [15:0] exp_l, input logic [15:0] exp_r);
    logic [15:0] lw, rw;
    logic [63:0] rest, lr, hi;
    wait_strobe({tag, "_strobe"});
    capture(mid_change, lw, rw, rest, lr, hi);
    chk({tag, "_left"},  {48'd0, lw}, {48'd0, exp_l});
    chk({tag, "_right"}, {48'd0, rw}, {48'd0, exp_r});
    chk({tag, "_pad"},   rest, 64'd0);
    chk({tag, "_lrck"},  lr, 64'hFFFF_FFFF_0000_0000);
    chk({tag, "_bclk"},  hi, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  initial begin
    int n;
    logic lr_a, lr_b;
    rst_n = 1'b0; exchan = 1'b0; mix = 1'b0; mute = 1'b0;
    ldata = 16'h0000; rdata = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {59'd0, aud_bclk, aud_daclrck, aud_dacdat, aud_xck, sample_strobe}, 64'd0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;                       // edge 1
    chk("xck_e1", {63'd0, aud_xck}, 64'd1);
    chk("bclk_e1", {63'd0, aud_bclk}, 64'd0);
    @(posedge clk); #1;                       // edge 2
    chk("xck_e2", {63'd0, aud_xck}, 64'd0);
    repeat (2) @(posedge clk); #1;            // edge 4
    chk("bclk_rise_e4", {63'd0, aud_bclk}, 64'd1);
    repeat (3) @(posedge clk); #1;            // edge 7
    chk("strobe_e7", {63'd0, sample_strobe}, 64'd0);
    @(posedge clk); #1;                       // edge 8
    chk("strobe_e8", {63'd0, sample_strobe}, 64'd1);
    chk("bclk_fall_e8", {63'd0, aud_bclk}, 64'd0);
    @(posedge clk); #1;                       // edge 9
    chk("strobe_e9", {63'd0, sample_strobe}, 64'd0);

    // Frame period and lrck half periods
    n = 0; lr_a = 1'bx; lr_b = 1'bx;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      if (i == 254) lr_a = aud_daclrck;       // edge 263
      if (i == 255) lr_b = aud_daclrck;       // edge 264
      if (sample_strobe) begin
        n = i + 1;
        break;
      end
    end
    chk("strobe_period", 64'(n), 64'd512);
    chk("lrck_e263", {63'd0, lr_a}, 64'd0);
    chk("lrck_e264", {63'd0, lr_b}, 64'd1);
    chk("lrck_e520", {63'd0, aud_daclrck}, 64'd0);

    // Serial data, swap, mix, mute
    ldata = 16'hA5F0; rdata = 16'h0F0F;
    frame_check("plain", 1'b0, 16'hA5F0, 16'h0F0F);
    exchan = 1'b1;
    frame_check("swap", 1'b0, 16'h0F0F, 16'hA5F0);
    exchan = 1'b0; mix = 1'b1; ldata = 16'h4000; rdata = 16'h4000;
    frame_check("mix4000", 1'b0, 16'h3000, 16'h3000);
    ldata = 16'h8000; rdata = 16'h8000;
    frame_check("mix8000", 1'b0, 16'hA000, 16'hA000);
    ldata = 16'h1000; rdata = 16'h2000;       // L=0800+0800, R=1000+0400
    frame_check("mix_asym", 1'b0, 16'h1000, 16'h1400);
    mute = 1'b1;
    frame_check("mute", 1'b0, 16'h0000, 16'h0000);

    // Latch isolation: ldata changes mid left slot
    mute = 1'b0; mix = 1'b0; ldata = 16'h1234; rdata = 16'h0F0F;
    frame_check("latch_cur", 1'b1, 16'h1234, 16'h0F0F);
    frame_check("latch_next", 1'b0, 16'hFFFF, 16'h0F0F);

    // Reset mid-frame
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (301) @(posedge clk);
    #1;
    chk("pre_reset_active", {62'd0, aud_xck, aud_daclrck}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {59'd0, aud_bclk, aud_daclrck, aud_dacdat, aud_xck, sample_strobe}, 64'd0);
    ldata = 16'h1234; rdata = 16'hC3A5;
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sample_strobe) begin
        n = i;
        break;
      end
    end
    chk("midrst_first_strobe", 64'(n), 64'd8);
    begin
      logic [15:0] lw, rw;
      logic [63:0] rest, lr, hi;
      capture(1'b0, lw, rw, rest, lr, hi);
      chk("midrst_left",  {48'd0, lw}, 64'h1234);
      chk("midrst_right", {48'd0, rw}, 64'hC3A5);
      chk("midrst_pad",   rest, 64'd0);
      chk("midrst_lrck",  lr, 64'hFFFF_FFFF_0000_0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
